demux_rr_scheduler: RTL and testbench
=====================================

DEMUX_RR_SCHEDULER -- requirements
Module: demux_rr_scheduler

Interface
REQ-001 Parameter CNT_W, default 16: width of the dwell counter and the dwell input.
REQ-002 Parameter GAP_CYC, default 1: idle cycles inserted after each grant; legal range 0..15.
REQ-003 Port clk  input  1: single clock; all logic on the rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port req  input  8: per-channel request; bit i requests routing to demux output i.
REQ-006 Port dwell  input  CNT_W: number of enabled cycles per grant; sampled at grant start.
REQ-007 Port sel  output  3: select code for the downstream 3-to-8 demux.
REQ-008 Port en  output  1: gate for the demux data input; high while routing is active.
REQ-009 Port grant  output  8: one-hot grant; equals (1 << sel) while en=1, otherwise 0.
REQ-010 Port busy  output  1: high in any state other than IDLE.
REQ-011 Port done  output  1: single-cycle pulse on successful completion of a grant.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT and GAP.
REQ-013 All outputs SHALL be registered.
REQ-014 The block SHALL keep a 3-bit round-robin pointer ptr.
REQ-015 In IDLE with req != 0, the block SHALL select the first set req bit found by searching ptr, ptr+1, ... mod 8.
REQ-016 On that selection, the block SHALL load sel, load the counter with dwell (dwell=0 treated as 1) and enter GRANT.
REQ-017 Latency: req asserted in cycle N while in IDLE SHALL give en=1, grant valid and sel valid in cycle N+1.
REQ-018 In IDLE with req == 0, the block SHALL stay in IDLE with en=0 and grant=0; sel SHALL hold its last value.
REQ-019 In GRANT, en SHALL be 1 and the counter SHALL decrement once per cycle; en SHALL be high for exactly max(dwell,1) cycles.
REQ-020 On the final GRANT cycle with req[sel]=1, done SHALL be 1 in that same cycle.
REQ-021 A grant SHALL end by leaving GRANT, either on completion or on abort.
REQ-022 At the end of every grant, ptr SHALL be set to sel+1 mod 8, wrapping 7 to 0.
REQ-023 At the end of every grant, the next state SHALL be GAP if GAP_CYC>0, else IDLE.
REQ-024 Abort: if req[sel]=0 in any GRANT cycle, that cycle SHALL be the last en cycle, and done SHALL be 0.
REQ-025 If req[sel] drops on the final count cycle, the grant SHALL be treated as an abort (no done).
REQ-026 Changes to dwell or to other req bits during GRANT SHALL have no effect on the current grant.
REQ-027 In GAP, en=0 and grant=0; sel SHALL hold; the block SHALL stay GAP_CYC cycles, then enter IDLE.
REQ-028 sel SHALL change only in a cycle where en=0 in both the previous and the current cycle.
REQ-029 With GAP_CYC=0, there SHALL be at least one IDLE cycle with en=0 between consecutive grants.
REQ-030 A continuously asserted req bit SHALL be granted within 8 grants (starvation-free).
REQ-031 done SHALL never be high when en=0; grant SHALL never have more than one bit set.

Reset
REQ-032 When reset=1 at a clock edge, the next cycle SHALL show state=IDLE, ptr=0, sel=0, en=0, grant=0, busy=0, done=0, counter=0.
REQ-033 Reset SHALL take priority over all other inputs.
REQ-034 Reset during GRANT SHALL drop en in the next cycle, with no done pulse and no ptr advance beyond 0.
REQ-035 After reset deasserts, arbitration SHALL resume from ptr=0 on the first IDLE cycle.

Verification
REQ-036 Single request: reset, then req=8'h04 and dwell=3 -> sel=2, grant=8'h04, en=1 for 3 cycles starting the cycle after req; done on the 3rd; then 1 GAP cycle; ptr=3.
REQ-037 Round-robin with wrap: req=8'h81 held, dwell=1, GAP_CYC=1 -> grant order 0,7,0,7...; ptr wraps from 7 to 0.
REQ-038 Dwell of zero: dwell=0 with req=8'h10 -> en high exactly 1 cycle, sel=4, done=1.
REQ-039 Abort: req=8'h02, dwell=10; drop req[1] during the 4th en cycle -> en ends after that cycle, done never asserts, ptr=2.
REQ-040 Reset mid-grant: assert reset in the 2nd cycle of a dwell=5 grant -> next cycle all outputs 0; new req=8'h01 -> sel=0 granted.
REQ-041 Glitch-free select: random req/dwell for 10k cycles -> sel never changes while en=1 or in the cycle after en=1; grant is always one-hot or zero.

Source files
------------

// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler driving a 3-to-8 demux: grants one requesting channel
// for a programmable dwell, then inserts GAP_CYC idle cycles before re-arbitrating.
module demux_rr_scheduler #(
   parameter int CNT_W   = 16,
   parameter int GAP_CYC = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       req,
   input  logic [CNT_W-1:0] dwell,
   output logic [2:0]       sel,
   output logic             en,
   output logic [7:0]       grant,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   localparam logic [CNT_W-1:0] GapLoad = CNT_W'(GAP_CYC);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   state_t           state_q;
   logic [2:0]       ptr_q;
   logic [2:0]       sel_q;
   logic             en_q;
   logic [7:0]       grant_q;
   logic             busy_q;
   logic [CNT_W-1:0] cnt_q;

   logic [2:0]       winner_d;
   logic             found_d;
   logic [CNT_W-1:0] dwellLoad_d;
   logic             grantEnd_d;

   // First requesting channel searching upward from the round-robin pointer.
   always_comb begin
      winner_d = ptr_q;
      found_d  = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (!found_d && req[ptr_q + 3'(k)]) begin
            winner_d = ptr_q + 3'(k);
            found_d  = 1'b1;
         end
      end
   end

   always_comb begin
      dwellLoad_d = (dwell == '0) ? CntOne : dwell;
      grantEnd_d  = !req[sel_q] || (cnt_q == CntOne);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= 3'd0;
         sel_q   <= 3'd0;
         en_q    <= 1'b0;
         grant_q <= 8'd0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (found_d) begin
                  state_q <= GRANT;
                  sel_q   <= winner_d;
                  en_q    <= 1'b1;
                  grant_q <= 8'd1 << winner_d;
                  busy_q  <= 1'b1;
                  cnt_q   <= dwellLoad_d;
               end
            end
            GRANT: begin
               // Completion and abort leave identically; only done tells them apart.
               if (grantEnd_d) begin
                  ptr_q   <= sel_q + 3'd1;
                  en_q    <= 1'b0;
                  grant_q <= 8'd0;
                  if (GAP_CYC > 0) begin
                     state_q <= GAP;
                     busy_q  <= 1'b1;
                     cnt_q   <= GapLoad;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     cnt_q   <= '0;
                  end
               end else begin
                  cnt_q <= cnt_q - CntOne;
               end
            end
            GAP: begin
               if (cnt_q <= CntOne) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q - CntOne;
               end
            end
            default: begin
               state_q <= IDLE;
               en_q    <= 1'b0;
               grant_q <= 8'd0;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // done must reflect req[sel] in the final grant cycle itself, so it is a
   // decode of registered state qualified by the live request bit.
   assign done  = en_q && (cnt_q == CntOne) && req[sel_q];
   assign sel   = sel_q;
   assign en    = en_q;
   assign grant = grant_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Bench for demux_rr_scheduler: directed scenarios plus random traffic, every
// cycle compared against a transaction-level model of the arbitration rules.
module tb_demux_rr_scheduler;

   localparam int CntW   = 16;
   localparam int GapCyc = 1;

   logic            clock;
   logic            reset;
   logic [7:0]      req;
   logic [CntW-1:0] dwell;
   logic [2:0]      sel;
   logic            en;
   logic [7:0]      grant;
   logic            busy;
   logic            done;

   int checks;
   int failures;

   // Model: remaining enabled cycles of the current grant, remaining gap cycles,
   // pointer and channel as plain integers.
   int  mRemain;
   int  mGapLeft;
   int  mPtr;
   int  mSel;
   bit  checkEn;

   demux_rr_scheduler #(.CNT_W(CntW), .GAP_CYC(GapCyc)) dut (
      .clk   (clock),
      .reset (reset),
      .req   (req),
      .dwell (dwell),
      .sel   (sel),
      .en    (en),
      .grant (grant),
      .busy  (busy),
      .done  (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [7:0] rq,
                                input logic [CntW-1:0] dw, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(posedge clock);
         #1;
         reset = r;
         req   = rq;
         dwell = dw;
      end
   endtask

   // Compare mid-cycle, then advance the model with this cycle's inputs.
   always @(negedge clock) begin
      bit         expEn;
      logic [7:0] expGrant;
      bit         expDone;
      expEn    = (mRemain > 0);
      expGrant = expEn ? 8'(1 << mSel) : 8'd0;
      expDone  = expEn && (mRemain == 1) && req[mSel];
      if (checkEn) begin
         checkOutput("en", 32'(en), 32'(expEn));
         checkOutput("sel", 32'(sel), 32'(mSel));
         checkOutput("grant", 32'(grant), 32'(expGrant));
         checkOutput("busy", 32'(busy), 32'(expEn || (mGapLeft > 0)));
         checkOutput("done", 32'(done), 32'(expDone));
         checkOutput("onehot", 32'($countones(grant) <= 1), 32'd1);
         checkOutput("doneNoEn", 32'(done & ~en), 32'd0);
      end
      if (reset) begin
         mRemain  = 0;
         mGapLeft = 0;
         mPtr     = 0;
         mSel     = 0;
         checkEn  = 1'b1;
      end else if (mRemain > 0) begin
         if (!req[mSel] || mRemain == 1) begin
            mPtr     = (mSel + 1) % 8;
            mRemain  = 0;
            mGapLeft = GapCyc;
         end else begin
            mRemain--;
         end
      end else if (mGapLeft > 0) begin
         mGapLeft--;
      end else if (req != 8'd0) begin
         for (int k = 0; k < 8; k++) begin
            if (req[(mPtr + k) % 8]) begin
               mSel = (mPtr + k) % 8;
               break;
            end
         end
         mRemain = (dwell == 0) ? 1 : int'(dwell);
      end
   end

   initial begin
      logic [7:0] rq;
      logic       rs;
      checks   = 0;
      failures = 0;
      checkEn  = 1'b0;
      mRemain  = 0;
      mGapLeft = 0;
      mPtr     = 0;
      mSel     = 0;
      reset    = 1'b1;
      req      = 8'd0;
      dwell    = '0;

      applyStimulus(1'b1, 8'h00, 16'd0, 2);
      applyStimulus(1'b0, 8'h00, 16'd0, 3);
      // Single request, dwell 3, then idle.
      applyStimulus(1'b0, 8'h04, 16'd3, 4);
      applyStimulus(1'b0, 8'h00, 16'd3, 3);
      // Two channels at opposite ends, dwell 1, pointer wraps.
      applyStimulus(1'b0, 8'h81, 16'd1, 12);
      applyStimulus(1'b0, 8'h00, 16'd1, 3);
      // Dwell of zero behaves as one.
      applyStimulus(1'b0, 8'h10, 16'd0, 2);
      applyStimulus(1'b0, 8'h00, 16'd0, 3);
      // Abort in the 4th enabled cycle of a dwell-10 grant.
      applyStimulus(1'b0, 8'h02, 16'd10, 4);
      applyStimulus(1'b0, 8'h00, 16'd10, 4);
      // Reset in the 2nd cycle of a dwell-5 grant, then a fresh request.
      applyStimulus(1'b0, 8'h08, 16'd5, 2);
      applyStimulus(1'b1, 8'h08, 16'd5, 1);
      applyStimulus(1'b0, 8'h01, 16'd2, 4);
      applyStimulus(1'b0, 8'h00, 16'd2, 3);

      rq = 8'h00;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 3) == 0) rq = 8'($urandom);
         if ($urandom_range(0, 7) == 0) rq = 8'd0;
         rs = ($urandom_range(0, 199) == 0);
         applyStimulus(rs, rq, 16'($urandom_range(0, 6)), 1);
      end
      applyStimulus(1'b0, 8'h00, 16'd0, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
